bcd_conv_scheduler: RTL and testbench
=====================================

# bcd_conv_scheduler

Shared, sequential binary-to-BCD conversion engine for the vending-machine display path. Up to NUM_REQ requesters (price, inserted amount, change due, stock count) each present an 8-bit value. A round-robin arbiter grants one requester at a time. A single shift-and-add-3 datapath converts the value one bit per clock and returns the hundreds, tens and ones digits with a done strobe tagged by requester ID. The block replaces one combinational converter per display source.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester conversion request, level-sensitive
- bin_in  input  8*NUM_REQ  operand of requester i at bits [8i+7:8i]
- grant  output  NUM_REQ  one-hot, one-cycle pulse; operand captured
- busy  output  1  high from the grant cycle through the done cycle inclusive
- done  output  1  one-cycle pulse; digits valid and updated
- done_id  output  3  index of the requester whose result is on the digit outputs
- hundreds  output  4  BCD hundreds digit, registered
- tens  output  4  BCD tens digit, registered
- ones  output  4  BCD ones digit, registered

## Operation
- States:
  - IDLE: waiting for a request.
  - CONV: 8 bit-steps, counter 7 down to 0.
  - DONE: one cycle, then back to IDLE.
- IDLE, edge with |req=1:
  - Winner is the first asserted req scanning upward from rr_ptr, wrapping at NUM_REQ-1 → 0.
  - Capture bin_in of the winner into the shift register and clear the working digits.
  - Assert grant[winner] for the next cycle. Set rr_ptr = winner+1 (mod NUM_REQ). Set counter to 7. Go to CONV.
- IDLE with req=0: hold; outputs unchanged.
- CONV, each edge:
  - For each working digit ≥5, add 3 (4-bit, no carry out).
  - Then shift {hundreds,tens,ones,operand} left 1; the operand MSB enters ones[0].
  - When counter=0, go to DONE. Otherwise decrement the counter.
- Entry to DONE:
  - Copy the working digits into hundreds/tens/ones.
  - Load done_id with the winner index. Assert done.
- DONE → IDLE unconditionally. DONE never arbitrates.
- req changes while busy are ignored. A requester still asserting req after done competes again in IDLE.
- Each digit result is ≤9. hundreds ≤2 for 8-bit input.
- rr_ptr resets to 0. Requester 0 wins all-simultaneous requests after reset.

## Timing
- Reset values (async, immediate):
  - State IDLE, rr_ptr=0.
  - grant=0, busy=0, done=0, done_id=0.
  - hundreds=tens=ones=0.
- Latency: req sampled at edge E → grant high in cycle E+1 → done high in cycle E+9.
- Throughput: one conversion per 10 cycles under continuous requests.
- busy is high for 9 cycles per conversion. It is low only in IDLE.
- Digit outputs change only at the edge that raises done, and hold until the next done.
- Reset mid-CONV:
  - Aborts the conversion; no done is issued.
  - Digits return to 0. The requester must re-request after reset release.
- Reset deassertion is synchronised externally; the block needs no extra cycle.

## Configuration
- BCD_SCHED_ZERO_BLANK_EN defined:
  - At the done update, hundreds is loaded with 4'hF if it is 0.
  - tens is loaded with 4'hF if both hundreds and tens are 0.
  - ones is never blanked. 4'hF is the segment decoder's blank code.
- Not defined: raw BCD digits are output, leading zeros included.

## Test plan
- Reset, then req=4'b0001, bin_in[7:0]=255 → grant=0001 one cycle later; done 8 cycles after grant; digits 2,5,5; done_id=0.
- Single conversions of 0, 9, 10, 99, 100, 128 → digits 000, 009, 010, 099, 100, 128. With BCD_SCHED_ZERO_BLANK_EN: 0 → F,F,0; 9 → F,F,9; 99 → F,9,9.
- req=4'b1111 held continuously → grant order 0,1,2,3,0, spaced 10 cycles apart; done_id tracks the grant order; busy low exactly 1 cycle between conversions.
- rr_ptr wrap: grant to 3, then req=4'b1001 → next grant is 0. With rr_ptr=2 and req=4'b0011 → grant is 0.
- Change bin_in and drop req during CONV → result reflects the captured operand only; no new grant until IDLE.
- Assert rst_n=0 at the 4th CONV cycle → all outputs 0 immediately; no done pulse; after release with req=0010 → grant=0010 and normal conversion.

Source files
------------

// File: rtl/bcd_conv_scheduler.sv
// Shared round-robin scheduled binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional leading-zero blanking of the digit outputs: define BCD_SCHED_ZERO_BLANK_EN.
module bcd_conv_scheduler #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] bin_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           done_id,
  output logic [3:0]           hundreds,
  output logic [3:0]           tens,
  output logic [3:0]           ones
);

  // state  | meaning
  // S_IDLE | waiting for a request; arbitrates round-robin from rr_ptr
  // S_CONV | 8 bit-steps of shift-and-add-3, counter 7 down to 0
  // S_DONE | result published for one cycle, no arbitration
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [2:0]           cur_id_q, cur_id_d;
  logic [7:0]           opr_q, opr_d;
  logic [11:0]          work_q, work_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2:0]           done_id_q, done_id_d;
  logic [11:0]          dig_q, dig_d;

  logic                 win_found;
  int                   win_idx;
  logic [11:0]          adj;
  logic [11:0]          step_work;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [11:0] blank(input logic [11:0] d);
    logic [11:0] r;
    r = d;
`ifdef BCD_SCHED_ZERO_BLANK_EN
    if (d[11:8] == 4'd0) r[11:8] = 4'hF;
    if (d[11:4] == 8'd0) r[7:4] = 4'hF;
`endif
    return r;
  endfunction

  // Scan downward so the lowest offset from rr_ptr is the last (winning) match.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[(int'(rr_ptr_q) + off) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = (int'(rr_ptr_q) + off) % NUM_REQ;
      end
    end
  end

  always_comb begin
    adj       = {add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};
    step_work = 12'({adj, opr_q[7]});
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    cur_id_d  = cur_id_q;
    opr_d     = opr_q;
    work_d    = work_q;
    grant_d   = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    dig_d     = dig_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
          opr_d    = bin_in[8*win_idx +: 8];
          work_d   = '0;
          cur_id_d = 3'(win_idx);
          rr_ptr_d = (win_idx == NUM_REQ - 1) ? 3'd0 : 3'(win_idx + 1);
          cnt_d    = 3'd7;
          busy_d   = 1'b1;
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        work_d = step_work;
        opr_d  = {opr_q[6:0], 1'b0};
        if (cnt_q == 3'd0) begin
          // Publish the result of the final step taken on this same edge.
          dig_d     = blank(step_work);
          done_id_d = cur_id_q;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= 3'd0;
      cnt_q     <= 3'd0;
      cur_id_q  <= 3'd0;
      opr_q     <= 8'd0;
      work_q    <= 12'd0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 3'd0;
      dig_q     <= 12'd0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      cur_id_q  <= cur_id_d;
      opr_q     <= opr_d;
      work_q    <= work_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      dig_q     <= dig_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign done_id  = done_id_q;
  assign hundreds = dig_q[11:8];
  assign tens     = dig_q[7:4];
  assign ones     = dig_q[3:0];

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed self-checking bench for bcd_conv_scheduler (NUM_REQ = 4).
module tb_bcd_conv_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] bin_in;
  logic [3:0]  grant;
  logic        busy;
  logic        done;
  logic [2:0]  done_id;
  logic [3:0]  hundreds;
  logic [3:0]  tens;
  logic [3:0]  ones;

  int n_chk;
  int n_pass;

  bcd_conv_scheduler #(.NUM_REQ(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .bin_in   (bin_in),
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] exp_dig(input logic [11:0] raw);
    logic [11:0] r;
    r = raw;
`ifdef BCD_SCHED_ZERO_BLANK_EN
    if (raw[11:8] == 4'd0) r[11:8] = 4'hF;
    if (raw[11:4] == 8'd0) r[7:4] = 4'hF;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Starts at a negedge in IDLE; ends at the negedge of the following IDLE cycle.
  task automatic conv(input logic [3:0] reqv, input int id, input logic [11:0] raw, input string tag);
    req = reqv;
    @(negedge clk);
    check({tag, " grant"}, 32'(grant), 32'h1 << id);
    check({tag, " busy_at_grant"}, 32'(busy), 32'd1);
    req = 4'b0000;
    repeat (7) @(negedge clk);
    check({tag, " done_early"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " done_id"}, 32'(done_id), 32'(id));
    check({tag, " digits"}, 32'({hundreds, tens, ones}), 32'(exp_dig(raw)));
    check({tag, " busy_at_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, " busy_idle"}, 32'(busy), 32'd0);
    check({tag, " done_drop"}, 32'(done), 32'd0);
  endtask

  logic [11:0] rr_exp [4];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    bin_in = 32'd0;
    repeat (2) @(negedge clk);
    check("rst grant", 32'(grant), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst done_id", 32'(done_id), 32'd0);
    check("rst digits", 32'({hundreds, tens, ones}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle no grant", 32'(grant), 32'd0);

    bin_in[7:0] = 8'd255; conv(4'b0001, 0, 12'h255, "v255");
    bin_in[7:0] = 8'd0;   conv(4'b0001, 0, 12'h000, "v0");
    bin_in[7:0] = 8'd9;   conv(4'b0001, 0, 12'h009, "v9");
    bin_in[7:0] = 8'd10;  conv(4'b0001, 0, 12'h010, "v10");
    bin_in[7:0] = 8'd99;  conv(4'b0001, 0, 12'h099, "v99");
    bin_in[7:0] = 8'd100; conv(4'b0001, 0, 12'h100, "v100");
    bin_in[7:0] = 8'd128; conv(4'b0001, 0, 12'h128, "v128");

    // Round robin from a fresh reset with all requesters held high.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bin_in = {8'd213, 8'd202, 8'd201, 8'd200};
    rr_exp[0] = 12'h200; rr_exp[1] = 12'h201; rr_exp[2] = 12'h202; rr_exp[3] = 12'h213;
    req = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("rr grant", 32'(grant), 32'h1 << (k % 4));
      if (k == 4) req = 4'b0000;
      repeat (8) @(negedge clk);
      check("rr done", 32'(done), 32'd1);
      check("rr done_id", 32'(done_id), 32'(k % 4));
      check("rr digits", 32'({hundreds, tens, ones}), 32'(rr_exp[k % 4]));
      @(negedge clk);
      check("rr busy gap", 32'(busy), 32'd0);
      @(negedge clk);
    end
    check("rr stop", 32'(grant), 32'd0);

    // rr_ptr = 1: grant 3, then 1001 wraps to 0; then rr_ptr = 2 with 0011 wraps to 0.
    conv(4'b1000, 3, 12'h213, "wrap3");
    conv(4'b1001, 0, 12'h200, "wrap0");
    conv(4'b0010, 1, 12'h201, "pre1");
    conv(4'b0011, 0, 12'h200, "wrap0b");

    // Operand and request changes during CONV are ignored.
    bin_in[23:16] = 8'd157;
    req = 4'b0100;
    @(negedge clk);
    check("cap grant", 32'(grant), 32'h4);
    bin_in[23:16] = 8'd42;
    req = 4'b1011;
    repeat (7) begin
      @(negedge clk);
      check("cap no grant", 32'(grant), 32'd0);
    end
    @(negedge clk);
    check("cap done", 32'(done), 32'd1);
    check("cap done_id", 32'(done_id), 32'd2);
    check("cap digits", 32'({hundreds, tens, ones}), 32'(exp_dig(12'h157)));
    @(negedge clk);
    check("cap idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("cap regrant", 32'(grant), 32'h8);
    req = 4'b0000;
    repeat (8) @(negedge clk);
    check("cap2 done", 32'(done), 32'd1);
    check("cap2 digits", 32'({hundreds, tens, ones}), 32'(exp_dig(12'h213)));
    @(negedge clk);

    // Reset in the 4th CONV cycle aborts the conversion.
    bin_in[7:0] = 8'd255;
    req = 4'b0001;
    @(negedge clk);
    check("abort grant", 32'(grant), 32'h1);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort digits", 32'({hundreds, tens, ones}), 32'd0);
    check("abort done_id", 32'(done_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("abort no done", 32'({done, busy}), 32'd0);
    end
    bin_in[15:8] = 8'd201;
    conv(4'b0010, 1, 12'h201, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
